// File: rtl/uart_pkg.sv
// uart_pkg: FSM state types and helpers shared by the uart_param_xcvr files.
// Parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Returns the parity bit for a word: even when odd=0, odd when odd=1.
  function automatic logic parity(input logic [8:0] d,
                                  input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through receive FIFO with sticky overrun.
// A pop in the same cycle as a push frees the slot the push needs.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_err_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overrun
);

  localparam int AW = clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic              r_ovr;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign w_drop  = i_push && o_full && !w_pop;
  assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign o_overrun = r_ovr;

  // Read/write pointers; the extra MSB tells full from empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
    end
  end

  // Storage; output is masked while empty so no reset is needed here.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  // Sticky overrun; a drop in the clear cycle keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ovr <= 1'b0;
    else if (w_drop)    r_ovr <= 1'b1;
    else if (i_err_clr) r_ovr <= 1'b0;
  end

endmodule

// File: rtl/uart_param_xcvr.sv
// uart_param_xcvr: full-duplex UART, shift-register TX, oversampled RX + FIFO.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_param_xcvr
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_wr_en,
  output logic              o_tx,
  output logic              o_tx_busy,
  input  logic              i_rx,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_ready,
  output logic              o_overrun,
  output logic              o_frame_err,
  output logic              o_parity_err,
  input  logic              i_err_clr
);

  localparam int CW = clog2(BAUD_DIV * STOP_BITS) + 1;
  localparam int BW = clog2(DATA_W) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(BAUD_DIV * STOP_BITS - 1);
  localparam logic [CW-1:0] MID      = CW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] LAST     = BW'(DATA_W - 1);

  tx_state_t         r_tx_st;
  logic [CW-1:0]     r_tcnt;
  logic [BW-1:0]     r_tbit;
  logic [DATA_W-1:0] r_tsh;
  logic              r_tx;
  logic              r_busy;

  rx_state_t         r_rx_st;
  logic              r_s1;
  logic              r_s2;
  logic [CW-1:0]     r_rcnt;
  logic [BW-1:0]     r_rbit;
  logic [DATA_W-1:0] r_rsh;
  logic              r_fe;
  logic              w_push;
  logic              w_full;
  logic              w_empty;

`ifdef UART_PARITY_EN
  logic              r_tpar;
  logic              r_pe;
  assign o_parity_err = r_pe;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_tx        = r_tx;
  assign o_tx_busy   = r_busy;
  assign o_frame_err = r_fe;
  assign o_ready     = !w_empty;

  // A good frame is pushed on its stop-bit mid-sample cycle.
  assign w_push = (r_rx_st == RX_STOP) &&
                  (r_rcnt == BIT_END) && r_s2;

  // TX FSM: each bit holds for BAUD_DIV cycles, stop for STOP_BITS of them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_st <= TX_IDLE;
      r_tcnt  <= '0;
      r_tbit  <= '0;
      r_tsh   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
`ifdef UART_PARITY_EN
      r_tpar  <= 1'b0;
`endif
    end else begin
      unique case (r_tx_st)
        TX_IDLE: begin
          if (i_wr_en) begin
            r_tsh   <= i_data_in;
`ifdef UART_PARITY_EN
            r_tpar  <= parity(9'(i_data_in), 1'(PARITY_ODD));
`endif
            r_tcnt  <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_tx_st <= TX_START;
          end
        end
        TX_START: begin
          if (r_tcnt == BIT_END) begin
            r_tcnt  <= '0;
            r_tbit  <= '0;
            r_tx    <= r_tsh[0];
            r_tsh   <= r_tsh >> 1;
            r_tx_st <= TX_DATA;
          end else r_tcnt <= r_tcnt + 1'b1;
        end
        TX_DATA: begin
          if (r_tcnt == BIT_END) begin
            r_tcnt <= '0;
            if (r_tbit == LAST) begin
`ifdef UART_PARITY_EN
              r_tx    <= r_tpar;
              r_tx_st <= TX_PARITY;
`else
              r_tx    <= 1'b1;
              r_tx_st <= TX_STOP;
`endif
            end else begin
              r_tbit <= r_tbit + 1'b1;
              r_tx   <= r_tsh[0];
              r_tsh  <= r_tsh >> 1;
            end
          end else r_tcnt <= r_tcnt + 1'b1;
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (r_tcnt == BIT_END) begin
            r_tcnt  <= '0;
            r_tx    <= 1'b1;
            r_tx_st <= TX_STOP;
          end else r_tcnt <= r_tcnt + 1'b1;
        end
`endif
        TX_STOP: begin
          if (r_tcnt == STOP_END) begin
            r_tcnt  <= '0;
            r_busy  <= 1'b0;
            r_tx_st <= TX_IDLE;
          end else r_tcnt <= r_tcnt + 1'b1;
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
    end
  end

  // RX FSM: detection cycle counts as tick 0, so samples land mid-bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_st <= RX_IDLE;
      r_rcnt  <= '0;
      r_rbit  <= '0;
      r_rsh   <= '0;
      r_fe    <= 1'b0;
`ifdef UART_PARITY_EN
      r_pe    <= 1'b0;
`endif
    end else begin
      if (i_err_clr) begin
        r_fe <= 1'b0;
`ifdef UART_PARITY_EN
        r_pe <= 1'b0;
`endif
      end
      unique case (r_rx_st)
        RX_IDLE: begin
          if (!r_s2) begin
            r_rcnt  <= CW'(1);
            r_rx_st <= RX_START;
          end
        end
        RX_START: begin
          if (r_rcnt == MID) begin
            r_rcnt  <= '0;
            r_rbit  <= '0;
            r_rx_st <= r_s2 ? RX_IDLE : RX_DATA;
          end else r_rcnt <= r_rcnt + 1'b1;
        end
        RX_DATA: begin
          if (r_rcnt == BIT_END) begin
            r_rcnt <= '0;
            r_rsh  <= {r_s2, r_rsh[DATA_W-1:1]};
            if (r_rbit == LAST) begin
`ifdef UART_PARITY_EN
              r_rx_st <= RX_PARITY;
`else
              r_rx_st <= RX_STOP;
`endif
            end else r_rbit <= r_rbit + 1'b1;
          end else r_rcnt <= r_rcnt + 1'b1;
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (r_rcnt == BIT_END) begin
            r_rcnt  <= '0;
            r_rx_st <= RX_STOP;
            if (r_s2 != parity(9'(r_rsh), 1'(PARITY_ODD)))
              r_pe <= 1'b1;
          end else r_rcnt <= r_rcnt + 1'b1;
        end
`endif
        RX_STOP: begin
          if (r_rcnt == BIT_END) begin
            r_rcnt <= '0;
            if (r_s2) r_rx_st <= RX_IDLE;
            else begin
              r_fe    <= 1'b1;
              r_rx_st <= RX_WAIT_HIGH;
            end
          end else r_rcnt <= r_rcnt + 1'b1;
        end
        RX_WAIT_HIGH: begin
          if (r_s2) r_rx_st <= RX_IDLE;
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (w_push),
    .i_data   (r_rsh),
    .i_pop    (i_rd_en),
    .i_err_clr(i_err_clr),
    .o_data   (o_data_out),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_overrun(o_overrun)
  );

endmodule

// File: tb/tb_uart_param_xcvr.sv
// tb_uart_param_xcvr: loopback and directly driven RX scenarios.
// Reference: frame bit slots and word order derived from the frame format.
module tb_uart_param_xcvr;

  localparam int BD  = 16;
  localparam int DW  = 8;
  localparam int SB  = 1;
  localparam int DEP = 4;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F   = (1 + DW + P + SB) * BD;
  localparam int LAT = 3 + F - (SB * BD - BD / 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          tx;
  logic          busy;
  logic          rx_drv = 1'b1;
  logic          loop = 1'b1;
  logic          rx_w;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          ready;
  logic          ovr;
  logic          fe;
  logic          pe;
  logic          err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  assign rx_w = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_param_xcvr #(
    .BAUD_DIV(BD), .DATA_W(DW), .STOP_BITS(SB),
    .FIFO_DEPTH(DEP), .PARITY_ODD(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data_in(din), .i_wr_en(wr_en),
    .o_tx(tx), .o_tx_busy(busy),
    .i_rx(rx_w), .i_rd_en(rd_en),
    .o_data_out(dout), .o_ready(ready),
    .o_overrun(ovr), .o_frame_err(fe),
    .o_parity_err(pe), .i_err_clr(err_clr)
  );

  // Expected line level in bit slot k of a frame carrying d.
  function automatic logic frame_bit(input logic [DW-1:0] d,
                                     input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    if (P == 1 && k == DW + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d);
    int t;
    t = 0;
    while (busy && t < 2 * F) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL send_wait busy=%b required=0", busy);
    end
    din = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic wait_ready(input int lim);
    int t;
    t = 0;
    while (!ready && t < lim) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic drive(input logic [DW-1:0] d,
                       input logic par, input logic stp);
    rx_drv = 1'b0;
    cyc(BD);
    for (int i = 0; i < DW; i++) begin
      rx_drv = d[i];
      cyc(BD);
    end
`ifdef UART_PARITY_EN
    rx_drv = par;
    cyc(BD);
`else
    if (par === 1'bx) cyc(0);
`endif
    rx_drv = stp;
    cyc(BD);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    checks++;
    if ({tx, busy, ready, ovr, fe, pe} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=100000",
               {tx, busy, ready, ovr, fe, pe});
    end
    checks++;
    if (dout !== '0) begin
      failures++;
      $display("FAIL reset_dout got=%h required=00", dout);
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_tx_frame();
    logic [DW-1:0] d;
    int bad, rdy_n, busy_bad;
    loop = 1'b1;
    for (int r = 0; r < 3; r++) begin
      d = DW'($urandom);
      din = d;
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      bad = 0;
      busy_bad = 0;
      rdy_n = 0;
      for (int n = 1; n <= F + BD; n++) begin
        if (n <= F && (tx !== frame_bit(d, (n - 1) / BD) ||
                       busy !== 1'b1)) bad++;
        if (n == F + 1 && busy !== 1'b0) busy_bad++;
        if (ready && rdy_n == 0) rdy_n = n;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL tx_frame data=%h bad_cycles=%0d required=0",
                 d, bad);
      end
      checks++;
      if (busy_bad != 0) begin
        failures++;
        $display("FAIL tx_busy_fall busy_high_at=%0d required_low",
                 F + 1);
      end
      checks++;
      if (rdy_n != LAT) begin
        failures++;
        $display("FAIL loop_latency got=%0d required=%0d", rdy_n, LAT);
      end
      checks++;
      if (dout !== d) begin
        failures++;
        $display("FAIL loop_data got=%h required=%h", dout, d);
      end
      pop();
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_after_pop got=%b required=0", ready);
      end
    end
  endtask

  task automatic test_loopback_all();
    logic [DW-1:0] q[$];
    logic [DW-1:0] e;
    loop = 1'b1;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          if ($urandom_range(0, 3) == 0) cyc(1);
          q.push_back(DW'(i));
          send(DW'(i));
        end
      end
      begin
        for (int i = 0; i < 256; i++) begin
          wait_ready(4 * F);
          checks++;
          if (ready !== 1'b1) begin
            failures++;
            $display("FAIL loop_wait idx=%0d ready=%b required=1",
                     i, ready);
            break;
          end
          cyc($urandom_range(0, 20));
          e = q.pop_front();
          checks++;
          if (dout !== e) begin
            failures++;
            $display("FAIL loop_word idx=%0d got=%h required=%h",
                     i, dout, e);
          end
          pop();
        end
      end
    join
    checks++;
    if ({ovr, fe, pe, ready} !== 4'b0000) begin
      failures++;
      $display("FAIL loop_flags ovr_fe_pe_rdy=%b required=0000",
               {ovr, fe, pe, ready});
    end
  endtask

  task automatic test_overrun();
    loop = 1'b1;
    for (int i = 0; i < 5; i++) send(DW'(8'h11 + i));
    wait_ready(2 * F);
    cyc(F + 2 * BD);
    checks++;
    if ({ovr, ready} !== 2'b11) begin
      failures++;
      $display("FAIL overrun_flags ovr_rdy=%b required=11",
               {ovr, ready});
    end
    for (int i = 0; i < DEP; i++) begin
      checks++;
      if (dout !== DW'(8'h11 + i) || ready !== 1'b1) begin
        failures++;
        $display("FAIL overrun_word idx=%0d got=%h rdy=%b required=%h",
                 i, dout, ready, DW'(8'h11 + i));
      end
      pop();
    end
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL overrun_lost ready=%b required=0", ready);
    end
    clear_errs();
    checks++;
    if (ovr !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr got=%b required=0", ovr);
    end
  endtask

  task automatic test_framing();
    loop = 1'b0;
    rx_drv = 1'b1;
    cyc(4);
    drive(8'hA5, ^8'hA5, 1'b0);
    cyc(2 * BD);
    checks++;
    if ({fe, ready} !== 2'b10) begin
      failures++;
      $display("FAIL frame_err fe_rdy=%b required=10", {fe, ready});
    end
    drive(8'h3C, ^8'h3C, 1'b1);
    cyc(BD);
    checks++;
    if (ready !== 1'b1 || dout !== 8'h3C) begin
      failures++;
      $display("FAIL frame_recover rdy=%b got=%h required=3c",
               ready, dout);
    end
    pop();
    clear_errs();
    checks++;
    if (fe !== 1'b0) begin
      failures++;
      $display("FAIL frame_clr got=%b required=0", fe);
    end
  endtask

  task automatic test_glitch();
    loop = 1'b0;
    rx_drv = 1'b0;
    cyc(BD / 4);
    rx_drv = 1'b1;
    cyc(2 * BD);
    checks++;
    if ({ready, ovr, fe, pe} !== 4'b0000) begin
      failures++;
      $display("FAIL glitch rdy_ovr_fe_pe=%b required=0000",
               {ready, ovr, fe, pe});
    end
    drive(8'h96, ^8'h96, 1'b1);
    cyc(BD);
    checks++;
    if (ready !== 1'b1 || dout !== 8'h96) begin
      failures++;
      $display("FAIL glitch_recover rdy=%b got=%h required=96",
               ready, dout);
    end
    pop();
  endtask

  task automatic test_parity();
    loop = 1'b0;
    drive(8'h07, 1'b0, 1'b1);
    cyc(BD);
`ifdef UART_PARITY_EN
    checks++;
    if ({pe, ready} !== 2'b11 || dout !== 8'h07) begin
      failures++;
      $display("FAIL parity_err pe_rdy=%b got=%h required=11/07",
               {pe, ready}, dout);
    end
    pop();
    clear_errs();
    checks++;
    if (pe !== 1'b0) begin
      failures++;
      $display("FAIL parity_clr got=%b required=0", pe);
    end
`else
    checks++;
    if (pe !== 1'b0 || ready !== 1'b1 || dout !== 8'h07) begin
      failures++;
      $display("FAIL parity_off pe=%b rdy=%b got=%h required=0/1/07",
               pe, ready, dout);
    end
    pop();
`endif
  endtask

  task automatic test_reset_mid();
    loop = 1'b1;
    send(8'h33);
    wait_ready(2 * F);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre ready=%b required=1", ready);
    end
    cyc(2 * BD);
    send(8'hC3);
    cyc(3 * BD);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, ready} !== 3'b100) begin
      failures++;
      $display("FAIL rstmid_now tx_busy_rdy=%b required=100",
               {tx, busy, ready});
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    send(8'h5A);
    wait_ready(2 * F);
    checks++;
    if (ready !== 1'b1 || dout !== 8'h5A) begin
      failures++;
      $display("FAIL rstmid_next rdy=%b got=%h required=5a",
               ready, dout);
    end
    pop();
    checks++;
    if ({ready, ovr, fe, pe} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_after rdy_ovr_fe_pe=%b required=0000",
               {ready, ovr, fe, pe});
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback_all();
    test_overrun();
    test_framing();
    test_glitch();
    test_parity();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_param_xcvr.md
# uart_param_xcvr

Parametrised full-duplex UART transceiver: a shift-register transmitter and an oversampled receiver that share one clock. The receiver stores frames in an RX FIFO with first-word fall-through, so it no longer uses the single-byte READY/READY_CLR holding register. Data width, baud divisor, stop-bit count and FIFO depth are configurable, and framing, overrun and optional parity errors are reported. It is the next-generation serial endpoint, and a TX-to-RX loopback bench exercises it.

## Interface
- BAUD_DIV, 16: clocks per bit; ≥4, even.
- DATA_W, 8: data bits per frame; 5..9; sent LSB first.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: RX FIFO entries; power of 2, ≥2.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only when UART_PARITY_EN is defined.

- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- DATA_IN  in  DATA_W  TX word, sampled on the WR_EN cycle.
- WR_EN  in  1  TX start request.
- TX  out  1  serial out; idles high.
- TX_BUSY  out  1  frame in progress.
- RX  in  1  serial in; asynchronous.
- RD_EN  in  1  pop the FIFO head.
- DATA_OUT  out  DATA_W  FIFO head, valid while READY.
- READY  out  1  FIFO non-empty.
- OVERRUN  out  1  sticky: a frame was dropped because the FIFO was full.
- FRAME_ERR  out  1  sticky: the stop bit was sampled low.
- PARITY_ERR  out  1  sticky: parity mismatch.
- ERR_CLR  in  1  clears all three sticky flags.

## Operation
- TX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE. Each bit lasts BAUD_DIV cycles. STOP lasts STOP_BITS×BAUD_DIV cycles.
- TX start: WR_EN with TX_BUSY=0 latches DATA_IN. WR_EN while TX_BUSY=1 is ignored and no word is queued.
- RX front end: 2-flop synchroniser on RX; both flops reset to 1.
- RX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE, plus WAIT_HIGH.
  - IDLE: a synchronised falling edge starts the BAUD_DIV counter.
  - START: re-sample at BAUD_DIV/2. If the line is high, the edge was a glitch; return to IDLE with no flag set.
  - DATA: sample each bit at its mid-point, every BAUD_DIV cycles.
  - STOP: only the first stop bit is checked.
- Stop bit sampled low: set FRAME_ERR, discard the word, go to WAIT_HIGH. WAIT_HIGH returns to IDLE once the line reads 1.
- Push: a valid frame is pushed into the FIFO on the stop-bit mid-sample cycle.
- FIFO full on push: the word is dropped and OVERRUN is set.
- RD_EN when empty: ignored.
- Push and pop in the same cycle: the pop is applied first, so the push is accepted even when the FIFO is full.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full and empty are derived from the MSB comparison.
- Sticky flags: an error event and ERR_CLR in the same cycle leaves the flag set.
- Reset mid-frame: both FSMs abort immediately. The FIFO empties and no partial word is ever pushed.

## Timing
- Reset values:
  - TX=1, TX_BUSY=0.
  - READY=0, DATA_OUT=0.
  - OVERRUN=0, FRAME_ERR=0, PARITY_ERR=0.
  - Both FSMs in IDLE.
- TX: a WR_EN accepted at cycle 0 drives TX_BUSY=1 and TX=0 from cycle 1.
- TX frame length: F = (1+DATA_W+P+STOP_BITS)×BAUD_DIV cycles, where P=1 if parity is enabled, else 0. TX_BUSY falls after cycle F; WR_EN is accepted on that same cycle.
- RX: READY rises 1 cycle after the stop-bit mid-sample.
- FIFO read: DATA_OUT updates to the next entry the cycle after RD_EN. READY falls the cycle after the last pop.
- Loopback: READY rises 3 + (F − (STOP_BITS−0.5)×BAUD_DIV) cycles after WR_EN.

## Configuration
- UART_PARITY_EN defined:
  - TX inserts a parity bit after the data bits.
  - RX checks the parity bit. On a mismatch it sets PARITY_ERR, still pushes the word, and frames still include a parity bit slot.
- UART_PARITY_EN undefined:
  - No parity bit is sent or expected; the PARITY states are absent.
  - PARITY_ERR is tied to 0 and PARITY_ODD is ignored.

## Structure
- Package uart_pkg holds:
  - the tx_state_t and rx_state_t enums;
  - a parity function (data, odd → bit);
  - the clog2 helper.
- Sub-module uart_rx_fifo: synchronous FIFO with first-word fall-through output, parametrised by DATA_W and FIFO_DEPTH. It provides push, pop, full and empty signals and holds the overrun detection.

## Test plan
- Loopback with defaults: send 0x00..0xFF back-to-back. Each word is read out in order, with no flags set.
- Overrun: with FIFO_DEPTH=4 and RD_EN held 0, send 0x11..0x15. Contents are 0x11..0x14, OVERRUN=1, READY=1, and 0x15 is lost.
- Framing error: drive RX with a frame for 0xA5 whose stop bit is 0. FRAME_ERR=1 and nothing is pushed. A following frame for 0x3C is received correctly after the line returns high.
- Glitch: pulse RX low for BAUD_DIV/4 cycles. The FSM returns to IDLE with no push and no flag.
- Parity (UART_PARITY_EN, even): inject 0x07 with parity bit 0. PARITY_ERR=1 and 0x07 is present in the FIFO. Pulsing ERR_CLR clears the flag.
- Reset mid-operation: assert RST_N=0 during TX DATA and RX DATA. TX=1, TX_BUSY=0 and READY=0 immediately. The next transfer of 0x5A succeeds.
